memoria_registrador_datapath: RTL and testbench

Small load/store datapath joining a 4-bit address adder (`somador`), a 32×64-bit register file (`registrador`) and a 32×64-bit data memory (`memoria`). The adder output is the memory address. Register port A is the memory write data, and memory read data is the register-file write data. It is used as a bring-up vehicle for register/memory transfers in the larger processor datapath.

---
 rtl/datapath_pkg.sv | 13 +
 rtl/memoria.sv | 29 ++
 rtl/registrador.sv | 32 +++
 rtl/somador.sv | 16 +
 rtl/memoria_registrador_datapath.sv | 60 ++++++
 tb/tb_memoria_registrador_datapath.sv | 179 +++++++++++++++++
 6 files changed

// File: rtl/datapath_pkg.sv
// Shared widths and types for the register/memory transfer datapath.
// Constants only; no logic, no latency, no backpressure.
package datapath_pkg;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 5;
    localparam int OP_W      = 4;
    localparam int N_ENTRIES = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] idx_t;

endpackage

// File: rtl/memoria.sv
// 32 x 64-bit data memory: combinational read, synchronous write at the same address.
// Write visible one edge later, no read bypass; never stalls.
module memoria
    import datapath_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  idx_t  ads,
    input  logic  we,
    input  word_t din,
    output word_t dout
);

    // Word 31 cannot be addressed by the adder but is kept and cleared like the rest.
    word_t mem_q [N_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[ads] <= din;
        end
    end

    assign dout = mem_q[ads];

endmodule

// File: rtl/registrador.sv
// 32 x 64-bit register file: one synchronous write port, two combinational read ports.
// Write visible one edge later, no read bypass; never stalls.
module registrador
    import datapath_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  word_t din,
    input  logic  we,
    input  idx_t  Rw,
    input  idx_t  Ra,
    input  idx_t  Rb,
    output word_t doutA,
    output word_t doutB
);

    word_t regs_q [N_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[Rw] <= din;
        end
    end

    assign doutA = regs_q[Ra];
    assign doutB = regs_q[Rb];

endmodule

// File: rtl/somador.sv
// 4-bit unsigned adder producing a 5-bit sum (memory address) and its carry.
// Purely combinational, zero latency; no flow control.
module somador
    import datapath_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output idx_t            soma,
    output logic            sinal
);

    // Zero-extend both operands so the carry lands in the top sum bit.
    assign soma  = {1'b0, a} + {1'b0, b};
    assign sinal = soma[ADDR_W-1];

endmodule

// File: rtl/memoria_registrador_datapath.sv
// Load/store bring-up datapath: adder addresses memory, reg port A stores, memory read loads.
// Single-edge write latency, combinational reads; no backpressure.
module memoria_registrador_datapath #(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int ADDR_W = datapath_pkg::ADDR_W,
    parameter int OP_W   = datapath_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [ADDR_W-1:0] soma,
    output logic              sinal,
    input  logic              weReg,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic [DATA_W-1:0] doutA,
    output logic [DATA_W-1:0] doutB,
    input  logic              weMem,
    output logic [DATA_W-1:0] doutMem
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] reg_rdata_a;

    somador u_somador (
        .a     (a),
        .b     (b),
        .soma  (mem_addr),
        .sinal (sinal)
    );

    registrador u_registrador (
        .clk   (clk),
        .rst   (rst),
        .din   (mem_rdata),
        .we    (weReg),
        .Rw    (Rw),
        .Ra    (Ra),
        .Rb    (Rb),
        .doutA (reg_rdata_a),
        .doutB (doutB)
    );

    memoria u_memoria (
        .clk  (clk),
        .rst  (rst),
        .ads  (mem_addr),
        .we   (weMem),
        .din  (reg_rdata_a),
        .dout (mem_rdata)
    );

    assign soma    = mem_addr;
    assign doutA   = reg_rdata_a;
    assign doutMem = mem_rdata;

endmodule

// File: tb/tb_memoria_registrador_datapath.sv
module tb_memoria_registrador_datapath;

    logic        clk;
    logic        rst;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [4:0]  soma;
    logic        sinal;
    logic        weReg;
    logic [4:0]  Rw;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [63:0] doutA;
    logic [63:0] doutB;
    logic        weMem;
    logic [63:0] doutMem;

    int vectors;
    int miscompares;

    localparam logic [63:0] VAL_X = 64'hDEADBEEF_00000001;
    localparam logic [63:0] VAL_A = 64'h0000_0000_0000_000A;
    localparam logic [63:0] VAL_B = 64'h0000_0000_0000_000B;

    memoria_registrador_datapath dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .soma    (soma),
        .sinal   (sinal),
        .weReg   (weReg),
        .Rw      (Rw),
        .Ra      (Ra),
        .Rb      (Rb),
        .doutA   (doutA),
        .doutB   (doutB),
        .weMem   (weMem),
        .doutMem (doutMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Load a register with an arbitrary value by overriding the memory read data for one edge.
    task automatic preload_reg(input logic [4:0] idx, input logic [63:0] val);
        force dut.mem_rdata = val;
        Rw = idx;
        weReg = 1'b1;
        edge_step();
        weReg = 1'b0;
        release dut.mem_rdata;
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        a = '0; b = '0; Rw = '0; Ra = '0; Rb = '0;
        weReg = 1'b0; weMem = 1'b0;
        #12;
        rst = 1'b0;
        edge_step();

        // Reset state of the whole register file and every reachable memory word.
        for (int i = 0; i < 32; i++) begin
            Ra = 5'(i);
            Rb = 5'(31 - i);
            #1;
            chk("rst_doutA", doutA, 64'd0);
            chk("rst_doutB", doutB, 64'd0);
        end
        for (int s = 0; s <= 30; s++) begin
            a = (s > 15) ? 4'd15 : 4'(s);
            b = 4'(s - ((s > 15) ? 15 : s));
            #1;
            chk("rst_soma", {59'd0, soma}, 64'(s));
            chk("rst_doutMem", doutMem, 64'd0);
        end

        // Adder limits.
        a = 4'd0;  b = 4'd0;  #1;
        chk("add_0_0_soma", {59'd0, soma}, 64'd0);
        chk("add_0_0_sinal", {63'd0, sinal}, 64'd0);
        a = 4'd15; b = 4'd15; #1;
        chk("add_15_15_soma", {59'd0, soma}, 64'd30);
        chk("add_15_15_sinal", {63'd0, sinal}, 64'd1);
        a = 4'd8;  b = 4'd8;  #1;
        chk("add_8_8_soma", {59'd0, soma}, 64'd16);
        chk("add_8_8_sinal", {63'd0, sinal}, 64'd1);
        a = 4'd7;  b = 4'd8;  #1;
        chk("add_7_8_soma", {59'd0, soma}, 64'd15);
        chk("add_7_8_sinal", {63'd0, sinal}, 64'd0);

        // Preloads: reg[3]=X, reg[4]=A, reg[8]=B, then mem[9]=B via a store.
        a = 4'd0; b = 4'd0;
        preload_reg(5'd3, VAL_X);
        preload_reg(5'd4, VAL_A);
        preload_reg(5'd8, VAL_B);
        Ra = 5'd3; #1;
        chk("preload_reg3", doutA, VAL_X);
        Ra = 5'd8; a = 4'd4; b = 4'd5; weMem = 1'b1;
        edge_step();
        weMem = 1'b0; #1;
        chk("preload_mem9", doutMem, VAL_B);

        // Store reg[3] to mem[5]; before the edge the old word must still read.
        Ra = 5'd3; a = 4'd2; b = 4'd3; weMem = 1'b1; #1;
        chk("store_no_bypass", doutMem, 64'd0);
        edge_step();
        weMem = 1'b0; #1;
        chk("store_mem5", doutMem, VAL_X);

        // Reload mem[5] into reg[7].
        Rw = 5'd7; Rb = 5'd7; weReg = 1'b1; #1;
        chk("load_no_bypass", doutB, 64'd0);
        edge_step();
        weReg = 1'b0; #1;
        chk("load_reg7", doutB, VAL_X);

        // Same-edge swap between reg[4] and mem[9].
        Ra = 5'd4; Rw = 5'd4; a = 4'd4; b = 4'd5; weReg = 1'b1; weMem = 1'b1;
        edge_step();
        weReg = 1'b0; weMem = 1'b0; #1;
        chk("swap_reg4", doutA, VAL_B);
        chk("swap_mem9", doutMem, VAL_A);

        // Write enables low across toggling inputs.
        for (int i = 0; i < 5; i++) begin
            a = 4'(3 * i + 1); b = 4'(i + 4); Ra = 5'(i + 3); Rw = 5'(i + 3);
            edge_step();
        end
        Ra = 5'd4; Rb = 5'd3; a = 4'd4; b = 4'd5; #1;
        chk("hold_reg4", doutA, VAL_B);
        chk("hold_reg3", doutB, VAL_X);
        chk("hold_mem9", doutMem, VAL_A);
        Rb = 5'd7; a = 4'd2; b = 4'd3; #1;
        chk("hold_reg7", doutB, VAL_X);
        chk("hold_mem5", doutMem, VAL_X);

        // Reset asserted between edges while writes are requested.
        Ra = 5'd3; a = 4'd1; b = 4'd0; weMem = 1'b1;
        edge_step();
        #1;
        chk("mid_mem1_written", doutMem, VAL_X);
        Rw = 5'd3; weReg = 1'b1;
        rst = 1'b1; #1;
        chk("mid_rst_doutMem", doutMem, 64'd0);
        chk("mid_rst_doutA", doutA, 64'd0);
        edge_step();
        chk("rst_edge_doutMem", doutMem, 64'd0);
        chk("rst_edge_doutA", doutA, 64'd0);
        weReg = 1'b0; weMem = 1'b0;
        rst = 1'b0;
        Ra = 5'd4; Rb = 5'd7; a = 4'd4; b = 4'd5; #1;
        chk("post_rst_reg4", doutA, 64'd0);
        chk("post_rst_reg7", doutB, 64'd0);
        chk("post_rst_mem9", doutMem, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
